ofmap_writeback: RTL and testbench
==================================

Name: ofmap_writeback

Overview:
Drain side of the convolution datapath. When a finished output row sits in the psum buffer, this block reads it out word by word. It applies shift, ReLU and saturation to each word and pushes the 8-bit results into the DRAM write FIFO with a linearly incrementing DRAM write address. It is the write-back counterpart of the DRAM-read/row-fill controller and sits between the psum buffer read port and the output FIFO.

Parameters:
PSUM_W, 16, signed psum word width
DATA_W, 8, output activation width (unsigned)
SHIFT, 4, arithmetic right shift applied before clamping
ROW_LEN, 8, psum words per output row (2..64)
ADDR_W, 10, DRAM write address width

Ports:
clk  in  1  clock
rst  in  1  reset
rowReady  in  1  single-cycle pulse: psum buffer holds a complete row
psumRdEn  out  1  psum buffer read strobe
psumRdAddr  out  6  psum buffer read address
psumRdData  in  PSUM_W  signed read data, valid exactly 1 cycle after psumRdEn
canWrite  in  1  output FIFO not full
DRAMwriteEn  out  1  FIFO push
DRAMwriteAddr  out  ADDR_W  DRAM address of the pushed word
DRAMwriteData  out  DATA_W  pushed activation
busy  out  1  row in progress
rowDone  out  1  single-cycle pulse after the last word of a row is pushed
overflow  out  1  sticky: rowReady lost

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock.
- Reset values: every output is 0, state IDLE, address counters 0, skid empty, pending flag 0.
- States and transitions:
  - IDLE: on rowReady, go to READ with rdIdx=0.
  - READ: issue psumRdEn with psumRdAddr=rdIdx in any cycle where canWrite=1 and the skid register is empty. rdIdx increments per issue. After issuing index ROW_LEN-1, go to DRAIN.
  - DRAIN: wait until the final word has been pushed. Pulse rowDone in the cycle of the final push, then go to IDLE, or straight to READ if the pending flag is set (the flag is cleared).
- Data path:
  - Read data returns 1 cycle after issue. It is processed combinationally as q = clamp(psumRdData >>> SHIFT, 0, 2^DATA_W-1): negative values become 0 (ReLU), large values saturate to 255.
  - If canWrite=1 in the return cycle, q is pushed that same cycle (DRAMwriteEn=1, DRAMwriteData=q, DRAMwriteAddr=current wrAddr). wrAddr then increments.
  - If canWrite=0, q is captured in a 1-entry skid register. Read issue stalls, and the skid word is pushed in the first cycle with canWrite=1. No read is issued in that same cycle.
- Ordering and throughput:
  - Words are pushed in psum address order.
  - No word is dropped or duplicated under any canWrite pattern.
  - Throughput is 1 word/cycle when canWrite stays high.
- Latency: rowReady at cycle t gives the first psumRdEn at t+1 and the first push at t+2. rowDone coincides with the ROW_LEN-th push.
- Addressing: wrAddr wraps modulo 2^ADDR_W and is never reset except by rst.
- rowReady while busy=1:
  - With pending=0: pending is set.
  - With pending=1 already: overflow is set (sticky until rst) and the request is discarded.
  - rowReady in the cycle rowDone pulses is treated as pending, so no cycle is lost.
- busy=1 in READ and DRAIN, and during the transition cycle.
- Reset mid-row: all state is cleared and the partial row is abandoned.

Optional Feature:
Macro: OFMAP_MAXPOOL_EN.
- Defined: horizontal 1x2 max pooling after ReLU/clamp. Words 2k and 2k+1 are compared and only the larger is pushed, giving ROW_LEN/2 pushes per row and wrAddr advancing by ROW_LEN/2. rowDone pulses with the last pooled push. An even-word pooled value is held in a register until its odd partner returns. ROW_LEN must be even.
- Undefined: ROW_LEN pushes per row, no pooling logic.

Decomposition:
- Shared package (cnn_pkg): state encoding (IDLE/READ/DRAIN), default widths PSUM_W/DATA_W/ADDR_W, psum address width 6.
- Sub-module ofmap_quant: combinational shift/ReLU/saturate. It is natural to reuse in other post-processing paths.
- FSM, skid register and counters stay in the top module.

Test Plan:
- Single row, canWrite=1, ROW_LEN=8, psum = {-5, 0, 16, 100, 4095, 4096, -32768, 32767}, SHIFT=4.
  - Required: pushes {0, 0, 1, 6, 255, 255, 0, 255} at addresses 0..7.
  - Required: first push 2 cycles after rowReady; rowDone with the 8th push.
- Backpressure: canWrite toggles 1,0,0,1 repeatedly during the row.
  - Required: 8 pushes in order, no duplicate or drop.
  - Required: psumRdEn never asserted while the skid is full.
- Back-to-back rows: second rowReady mid-row.
  - Required: pending flag set; second row's first psumRdEn in the cycle after rowDone.
  - Required: addresses continue 8..15; overflow stays 0.
- Third rowReady while pending=1 -> overflow=1 and stays 1; only 2 rows are written.
- Address wrap, ADDR_W=4: after 2 rows the address wraps 15->0 on the third row.
- OFMAP_MAXPOOL_EN defined, psum>>4 = {3, 9, 200, 1, 0, 0, 7, 7} -> pushes {9, 200, 0, 7} at addresses 0..3; rowDone with the 4th push.
- rst asserted mid-row -> all outputs are 0 immediately; the next rowReady starts at address 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared widths and state encoding for the convolution datapath blocks.
package cnn_pkg;

  localparam int unsigned DefPsumW  = 16;
  localparam int unsigned DefDataW  = 8;
  localparam int unsigned DefAddrW  = 10;
  localparam int unsigned PsumAddrW = 6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StDrain = 2'd2
  } wb_state_e;

endpackage

// File: rtl/ofmap_quant.sv
// Combinational psum post-processing: arithmetic shift, ReLU and unsigned saturation.
module ofmap_quant
  import cnn_pkg::*;
#(
  parameter int unsigned PSUM_W = DefPsumW,
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned SHIFT  = 4
) (
  input  logic [PSUM_W-1:0] i_psum,
  output logic [DATA_W-1:0] o_q
);

  localparam int unsigned MaxQ = (1 << DATA_W) - 1;

  logic signed [PSUM_W-1:0] w_shift;

  assign w_shift = $signed(i_psum) >>> SHIFT;

  always_comb begin
    if (w_shift[PSUM_W-1]) begin
      o_q = '0;
    end else if (w_shift[PSUM_W-2:0] > (PSUM_W-1)'(MaxQ)) begin
      o_q = '1;
    end else begin
      o_q = w_shift[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ofmap_writeback.sv
// Drains finished psum rows into the DRAM write FIFO through a 1-entry skid register.
// Define OFMAP_MAXPOOL_EN for 1x2 horizontal max pooling (ROW_LEN must then be even).
module ofmap_writeback
  import cnn_pkg::*;
#(
  parameter int unsigned PSUM_W  = DefPsumW,
  parameter int unsigned DATA_W  = DefDataW,
  parameter int unsigned SHIFT   = 4,
  parameter int unsigned ROW_LEN = 8,
  parameter int unsigned ADDR_W  = DefAddrW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rowReady,
  output logic              psumRdEn,
  output logic [5:0]        psumRdAddr,
  input  logic [PSUM_W-1:0] psumRdData,
  input  logic              canWrite,
  output logic              DRAMwriteEn,
  output logic [ADDR_W-1:0] DRAMwriteAddr,
  output logic [DATA_W-1:0] DRAMwriteData,
  output logic              busy,
  output logic              rowDone,
  output logic              overflow
);

  wb_state_e              r_state;
  logic [PsumAddrW-1:0]   r_rdIdx;
  logic [ADDR_W-1:0]      r_wrAddr;
  logic                   r_rdValid;
  logic                   r_skidValid;
  logic [DATA_W-1:0]      r_skidData;
  logic                   r_pending;
  logic                   r_overflow;

  logic [DATA_W-1:0]      w_q;
  logic [DATA_W-1:0]      w_cand;
  logic                   w_candValid;
  logic                   w_issue;
  logic                   w_push;
  logic                   w_rowDone;
  logic                   w_lastIdx;

  ofmap_quant #(
    .PSUM_W(PSUM_W),
    .DATA_W(DATA_W),
    .SHIFT (SHIFT)
  ) u_quant (
    .i_psum(psumRdData),
    .o_q   (w_q)
  );

`ifdef OFMAP_MAXPOOL_EN
  logic              r_odd;
  logic [DATA_W-1:0] r_pool;

  // Even words park in r_pool; the odd partner produces the pushable maximum.
  assign w_cand      = (w_q > r_pool) ? w_q : r_pool;
  assign w_candValid = r_rdValid && r_odd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_odd  <= 1'b0;
      r_pool <= '0;
    end else if (r_rdValid) begin
      r_odd <= ~r_odd;
      if (!r_odd) r_pool <= w_q;
    end
  end
`else
  assign w_cand      = w_q;
  assign w_candValid = r_rdValid;
`endif

  assign w_issue   = (r_state == StRead) && canWrite && !r_skidValid;
  assign w_push    = canWrite && (r_skidValid || w_candValid);
  // Only the row's final word can still be outstanding once in DRAIN.
  assign w_rowDone = (r_state == StDrain) && w_push;
  assign w_lastIdx = (r_rdIdx == PsumAddrW'(ROW_LEN - 1));

  assign psumRdEn      = w_issue;
  assign psumRdAddr    = r_rdIdx;
  assign DRAMwriteEn   = w_push;
  assign DRAMwriteAddr = r_wrAddr;
  assign DRAMwriteData = w_push ? (r_skidValid ? r_skidData : w_cand) : '0;
  assign busy          = (r_state != StIdle);
  assign rowDone       = w_rowDone;
  assign overflow      = r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_rdIdx     <= '0;
      r_wrAddr    <= '0;
      r_rdValid   <= 1'b0;
      r_skidValid <= 1'b0;
      r_skidData  <= '0;
      r_pending   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_rdValid <= w_issue;
      if (w_push) r_wrAddr <= r_wrAddr + ADDR_W'(1);

      if (w_candValid && !canWrite) begin
        r_skidValid <= 1'b1;
        r_skidData  <= w_cand;
      end else if (w_push && r_skidValid) begin
        r_skidValid <= 1'b0;
      end

      if (rowReady && (r_state != StIdle) && !w_rowDone) begin
        if (r_pending) r_overflow <= 1'b1;
        else           r_pending  <= 1'b1;
      end

      case (r_state)
        StIdle: begin
          if (rowReady) begin
            r_state <= StRead;
            r_rdIdx <= '0;
          end
        end
        StRead: begin
          if (w_issue) begin
            r_rdIdx <= r_rdIdx + PsumAddrW'(1);
            if (w_lastIdx) r_state <= StDrain;
          end
        end
        StDrain: begin
          if (w_rowDone) begin
            // A request arriving with the final push queues behind the pending row.
            if (r_pending || rowReady) begin
              r_state   <= StRead;
              r_rdIdx   <= '0;
              r_pending <= r_pending && rowReady;
            end else begin
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writeback.sv
// Directed bench for ofmap_writeback with a push scoreboard; honours OFMAP_MAXPOOL_EN.
module tb_ofmap_writeback;

  localparam int ROW_LEN = 8;
`ifdef OFMAP_MAXPOOL_EN
  localparam int NOUT      = ROW_LEN / 2;
  localparam int FIRST_LAT = 3;
`else
  localparam int NOUT      = ROW_LEN;
  localparam int FIRST_LAT = 2;
`endif

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    logic       last;
    logic       first;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        rowReady;
  logic        psumRdEn;
  logic [5:0]  psumRdAddr;
  logic [15:0] psumRdData;
  logic        canWrite;
  logic        DRAMwriteEn;
  logic [3:0]  DRAMwriteAddr;
  logic [7:0]  DRAMwriteData;
  logic        busy;
  logic        rowDone;
  logic        overflow;

  logic signed [15:0] mem [64];
  sb_t                sbq [$];
  logic [3:0]         exp_addr;
  int                 checks;
  int                 errors;
  int                 cyc;
  int                 rd0_cyc;
  int                 first_push_cyc;
  int                 last_done_cyc;
  int                 prev_done_cyc;
  logic               prev_en;

`ifdef OFMAP_MAXPOOL_EN
  logic signed [15:0] rowa [ROW_LEN] = '{16'sd48, 16'sd144, 16'sd3200, 16'sd16,
                                         16'sd0, 16'sd0, 16'sd112, 16'sd112};
  logic [7:0]         expa [NOUT]    = '{8'd9, 8'd200, 8'd0, 8'd7};
`else
  logic signed [15:0] rowa [ROW_LEN] = '{-16'sd5, 16'sd0, 16'sd16, 16'sd100,
                                         16'sd4095, 16'sd4096, -16'sd32768, 16'sd32767};
  logic [7:0]         expa [NOUT]    = '{8'd0, 8'd0, 8'd1, 8'd6, 8'd255, 8'd255, 8'd0, 8'd255};
`endif
  logic signed [15:0] rowb [ROW_LEN] = '{-16'sd100, 16'sd300, 16'sd1000, 16'sd2000,
                                         16'sd5000, -16'sd1, 16'sd80, 16'sd33};

  ofmap_writeback #(
    .ROW_LEN(ROW_LEN),
    .ADDR_W (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .rowReady     (rowReady),
    .psumRdEn     (psumRdEn),
    .psumRdAddr   (psumRdAddr),
    .psumRdData   (psumRdData),
    .canWrite     (canWrite),
    .DRAMwriteEn  (DRAMwriteEn),
    .DRAMwriteAddr(DRAMwriteAddr),
    .DRAMwriteData(DRAMwriteData),
    .busy         (busy),
    .rowDone      (rowDone),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Psum buffer model: data valid one cycle after the strobe, junk otherwise.
  always @(posedge clk) begin
    psumRdData <= psumRdEn ? mem[psumRdAddr] : 16'($urandom);
  end

  function automatic logic [7:0] quant(input logic signed [15:0] p);
    int v;
    v = int'(p) >>> 4;
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rden"}, psumRdEn, 0);
    check({tag, "_wren"}, DRAMwriteEn, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, rowDone, 0);
    check({tag, "_ovf"}, overflow, 0);
    check({tag, "_waddr"}, DRAMwriteAddr, 0);
    check({tag, "_raddr"}, psumRdAddr, 0);
    check({tag, "_wdata"}, DRAMwriteData, 0);
  endtask

  task automatic load_row(input logic signed [15:0] r [ROW_LEN]);
    for (int k = 0; k < ROW_LEN; k++) mem[k] = r[k];
  endtask

  task automatic enqueue_row();
    logic [7:0] v;
    logic [7:0] a;
    logic [7:0] b;
    for (int k = 0; k < NOUT; k++) begin
`ifdef OFMAP_MAXPOOL_EN
      a = quant(mem[2*k]);
      b = quant(mem[2*k+1]);
      v = (a > b) ? a : b;
`else
      a = quant(mem[k]);
      b = a;
      v = a;
`endif
      sbq.push_back('{addr: exp_addr, data: v, last: (k == NOUT - 1), first: (k == 0)});
      exp_addr++;
    end
  endtask

  task automatic sample();
    sb_t e;
    if (DRAMwriteEn) begin
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("wr_addr", DRAMwriteAddr, e.addr);
        check("wr_data", DRAMwriteData, e.data);
        check("row_done", rowDone, e.last);
        if (e.first) first_push_cyc = cyc;
      end
    end else begin
      check("row_done_nopush", rowDone, 0);
    end
    if (psumRdEn) begin
      check("rd_needs_canwrite", canWrite, 1);
      // A push with no read in the previous cycle comes from the skid register.
      check("rd_during_skid_push", DRAMwriteEn && !prev_en, 0);
      if (psumRdAddr == 6'd0) rd0_cyc = cyc;
    end
    if (rowDone) begin
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
    end
    prev_en = psumRdEn;
  endtask

  task automatic tick(input logic cw, input logic rr);
    @(posedge clk);
    #1;
    canWrite = cw;
    rowReady = rr;
    cyc++;
    @(negedge clk);
    sample();
  endtask

  task automatic run_until_empty(input int bound);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < bound) begin
      tick(1'b1, 1'b0);
      n++;
    end
    check("drain_timeout", sbq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_a;
    int t_f;
    checks = 0;
    errors = 0;
    cyc = 0;
    rd0_cyc = -1;
    first_push_cyc = -1;
    last_done_cyc = -1;
    prev_done_cyc = -1;
    prev_en = 1'b0;
    exp_addr = '0;
    rst = 1'b1;
    canWrite = 1'b0;
    rowReady = 1'b0;
    for (int k = 0; k < 64; k++) mem[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    check_idle("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle("post_rst");

    // Row A: full throughput, quantisation corners.
    load_row(rowa);
    for (int k = 0; k < NOUT; k++) begin
      sbq.push_back('{addr: exp_addr, data: expa[k], last: (k == NOUT - 1), first: (k == 0)});
      exp_addr++;
    end
    tick(1'b1, 1'b1);
    t_a = cyc;
    run_until_empty(40);
    check("first_rd_lat", rd0_cyc - t_a, 1);
    check("first_push_lat", first_push_cyc - t_a, FIRST_LAT);
    check("done_lat", last_done_cyc - t_a, ROW_LEN + 1);
    repeat (3) tick(1'b1, 1'b0);
    check("idle_after_a", busy, 0);

    // Row B under backpressure, row C pending, row D overflows.
    load_row(rowb);
    for (int i = 0; i < 200 && (i < 8 || sbq.size() != 0); i++) begin
      if (i == 0 || i == 3) enqueue_row();
      tick((i >= 10) || (i % 4 == 0) || (i % 4 == 3), (i == 0) || (i == 3) || (i == 6));
      if (i == 5) check("ovf_before", overflow, 0);
      if (i == 7) check("ovf_set", overflow, 1);
    end
    check("bc_drained", sbq.size(), 0);
    check("pending_restart", rd0_cyc - prev_done_cyc, 1);
    repeat (4) tick(1'b1, 1'b0);
    check("idle_after_c", busy, 0);
    check("ovf_sticky", overflow, 1);

    // Row E abandoned by reset mid-row.
    load_row(rowa);
    enqueue_row();
    tick(1'b1, 1'b1);
    repeat (4) tick(1'b1, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    sbq.delete();
    exp_addr = '0;
    prev_en = 1'b0;
    #5;
    rst = 1'b0;
    canWrite = 1'b1;
    rowReady = 1'b0;

    // Row F restarts from address 0.
    load_row(rowb);
    enqueue_row();
    tick(1'b1, 1'b1);
    t_f = cyc;
    run_until_empty(40);
    check("f_first_push", first_push_cyc - t_f, FIRST_LAT);
    check("f_ovf_clear", overflow, 0);
    repeat (3) tick(1'b1, 1'b0);
    check("idle_after_f", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
